// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: ASCII constants, the
// per-character data width, the serializer state encoding and a helper that
// turns a 4-bit nibble into its uppercase ASCII hex digit.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam int         UART_DATA_BITS = 8;

    // Serializer state: one start bit, UART_DATA_BITS data bits, one stop bit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 0..9 -> '0'..'9' (0x30..0x39), 10..15 -> 'A'..'F' (0x41..0x46).
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'b0000, n};
        end else begin
            return 8'h37 + {4'b0000, n};
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 serializer, LSB first. Each bit is held for CLKS_PER_BIT
// clock cycles. A new byte may be started either from idle or in the very
// last cycle of the stop bit, so back-to-back bytes leave no idle gap.
//
// Ports
//   clk             system clock
//   rst             asynchronous active-low reset
//   i_start         load i_byte and begin a frame (honoured in IDLE or in the
//                   final stop-bit cycle)
//   i_byte          byte to serialize
//   o_tx            serial line, idles high (registered)
//   o_busy          high whenever a frame is in progress
//   o_bit_done_last high during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_bit_done_last
);

    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t       state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    wire baud_end = (baud == BAUD_LAST);

    assign o_busy          = (state != ST_IDLE);
    assign o_bit_done_last = (state == ST_STOP) && baud_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_tx    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud <= '0;
                    if (i_start) begin
                        shreg <= i_byte;
                        o_tx  <= 1'b0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        o_tx    <= shreg[0];
                        state   <= ST_DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == BIT_LAST) begin
                            o_tx  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            // shreg[0] is the bit on the line; shift the next one down.
                            o_tx    <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end

                ST_STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        // Chaining straight into the next start bit keeps characters contiguous.
                        if (i_start) begin
                            shreg <= i_byte;
                            o_tx  <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// -----------------------------------------------------------------------------
// uart_hex_tx
// Sends a 16-bit word on a UART line as four uppercase ASCII hex digits,
// most significant nibble first, optionally followed by CR LF. This module is
// the message sequencer; bit timing lives in uart_tx_byte.
//
// Handshake: a word is accepted on a rising clock edge where i_valid and
// o_ready are both high. o_ready is high only while the block is idle;
// i_valid is ignored at all other times, and i_data is sampled only at the
// accepting edge.
//
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   i_valid  word available
//   i_data   word to send
//   o_ready  idle and able to accept a word
//   o_tx     UART serial line, idles high
//   o_busy   high from the cycle after accept until the last stop bit ends
//   o_done   one-cycle pulse in the first idle cycle after a message
// -----------------------------------------------------------------------------
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NEWLINE      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int         N_CHARS   = 4 + 2 * NEWLINE;
    localparam logic [2:0] LAST_CHAR = 3'(N_CHARS - 1);

    logic [15:0] data_q;
    logic [2:0]  char_idx;
    logic        ser_busy;
    logic        ser_last;
    logic        ser_start;
    logic [7:0]  ser_byte;
    logic        accept;
    logic        more_chars;

    // Character for a given message position, derived from the captured word;
    // positions 4 and 5 only occur when NEWLINE is set.
    function automatic logic [7:0] char_at(input logic [15:0] w, input logic [2:0] idx);
        case (idx)
            3'd0:    return nibble_to_ascii(w[15:12]);
            3'd1:    return nibble_to_ascii(w[11:8]);
            3'd2:    return nibble_to_ascii(w[7:4]);
            3'd3:    return nibble_to_ascii(w[3:0]);
            3'd4:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    assign o_ready    = !ser_busy;
    assign o_busy     = ser_busy;
    assign accept     = i_valid && o_ready;
    assign more_chars = ser_last && (char_idx != LAST_CHAR);
    assign ser_start  = accept || more_chars;

    // The first character comes straight from i_data so the start bit can
    // begin on the cycle right after the accepting edge.
    assign ser_byte = accept ? nibble_to_ascii(i_data[15:12])
                             : char_at(data_q, char_idx + 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            char_idx <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= ser_last && (char_idx == LAST_CHAR);
            if (accept) begin
                data_q   <= i_data;
                char_idx <= '0;
            end else if (more_chars) begin
                char_idx <= char_idx + 3'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk            (clk),
        .rst            (rst),
        .i_start        (ser_start),
        .i_byte         (ser_byte),
        .o_tx           (o_tx),
        .o_busy         (ser_busy),
        .o_bit_done_last(ser_last)
    );

endmodule

// File: tb/tb_uart_hex_tx.sv
module tb_uart_hex_tx;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid1, valid2;
  logic [15:0] data1, data2;
  logic        ready1, tx1, busy1, done1;
  logic        ready2, tx2, busy2, done2;

  uart_hex_tx #(.CLKS_PER_BIT(CPB), .NEWLINE(1)) dut (
    .clk(clk), .rst(rst_n), .i_valid(valid1), .i_data(data1),
    .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
  );

  uart_hex_tx #(.CLKS_PER_BIT(CPB), .NEWLINE(0)) dut_nl0 (
    .clk(clk), .rst(rst_n), .i_valid(valid2), .i_data(data2),
    .o_ready(ready2), .o_tx(tx2), .o_busy(busy2), .o_done(done2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- line monitor ----------------
  logic sel = 1'b0;
  wire  mon_tx   = sel ? tx2 : tx1;
  wire  mon_done = sel ? done2 : done1;

  logic [7:0] rx_q[$];
  int         st_q[$];
  int         done_cnt = 0;
  int         ferr = 0;

  initial begin
    logic [7:0] b;
    int sc;
    forever begin
      @(negedge clk);
      if (mon_done === 1'b1) done_cnt++;
      if (rst_n === 1'b1 && mon_tx === 1'b0) begin
        sc = cyc;
        repeat (2) @(negedge clk);
        if (mon_tx !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = mon_tx;
        end
        repeat (4) @(negedge clk);
        if (mon_tx !== 1'b1) ferr++;
        rx_q.push_back(b);
        st_q.push_back(sc);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
    done_cnt = 0;
    ferr = 0;
  endtask

  task automatic push_str(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                          input logic [7:0] c3, input int with_nl);
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    exp_q.push_back(c2);
    exp_q.push_back(c3);
    if (with_nl != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Compare n received characters starting at rx_q[base]; first start bit at
  // cycle 'first', following characters exactly 10*CPB cycles apart.
  task automatic check_msg(input string tag, input int base, input int first, input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      int idx = base + k;
      e = exp_q.pop_front();
      if (idx < rx_q.size()) begin
        check($sformatf("%s_byte%0d", tag, k), rx_q[idx], e);
        if (k == 0) check($sformatf("%s_start%0d", tag, k), st_q[idx], first);
        else        check($sformatf("%s_start%0d", tag, k), st_q[idx], st_q[idx-1] + 10*CPB);
      end else begin
        check($sformatf("%s_missing%0d", tag, k), rx_q.size(), idx + 1);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int dc);
    int b = budget;
    while (mon_done !== 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check({tag, "_done_seen"}, mon_done, 1'b1);
    dc = cyc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc, dc, seen;
    logic [39:0] samp, exp40;
    logic [9:0]  pat10;

    rst_n = 1'b0; valid1 = 1'b1; data1 = 16'h1A3F; valid2 = 1'b0; data2 = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_tx",    tx1,    1'b1);
    check("rst_busy",  busy1,  1'b0);
    check("rst_done",  done1,  1'b0);
    check("rst_ready", ready1, 1'b1);
    check("rst_tx2",   tx2,    1'b1);
    valid1 = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_tx",   tx1,         1'b1);
    check("post_rst_busy", busy1,       1'b0);
    check("post_rst_rx",   rx_q.size(), 0);

    // T1: basic message, latency and done timing
    clear_sb();
    push_str(8'h31, 8'h41, 8'h33, 8'h46, 1);
    data1 = 16'h1A3F; valid1 = 1'b1;
    @(negedge clk); acc = cyc; valid1 = 1'b0;
    check("t1_latency_tx", tx1,    1'b0);
    check("t1_busy_start", busy1,  1'b1);
    check("t1_ready_low",  ready1, 1'b0);
    repeat (119) @(negedge clk);
    check("t1_busy_mid", busy1, 1'b1);
    repeat (120) @(negedge clk);
    check("t1_pre_done",  done1, 1'b0);
    check("t1_busy_last", busy1, 1'b1);
    @(negedge clk);
    check("t1_done",       done1,  1'b1);
    check("t1_done_ready", ready1, 1'b1);
    check("t1_done_busy",  busy1,  1'b0);
    check("t1_done_tx",    tx1,    1'b1);
    @(negedge clk);
    check("t1_done_pulse", done1, 1'b0);
    check_msg("t1", 0, acc, 6);
    check("t1_done_cnt", done_cnt, 1);

    // T2: raw bit pattern of '0' and contiguity
    clear_sb();
    push_str(8'h30, 8'h30, 8'h30, 8'h30, 1);
    pat10 = 10'b1001100000;
    for (int j = 0; j < 40; j++) exp40[j] = pat10[j/4];
    data1 = 16'h0000; valid1 = 1'b1;
    @(negedge clk); acc = cyc; valid1 = 1'b0;
    samp[0] = tx1;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      samp[j] = tx1;
    end
    check("t2_pattern", samp, exp40);
    wait_done("t2", 300, dc);
    check("t2_done_cyc", dc, acc + 240);
    @(negedge clk);
    check_msg("t2", 0, acc, 6);

    // T3: back-to-back with i_valid held high
    clear_sb();
    push_str(8'h46, 8'h46, 8'h46, 8'h46, 1);
    push_str(8'h42, 8'h45, 8'h45, 8'h46, 1);
    data1 = 16'hFFFF; valid1 = 1'b1;
    @(negedge clk); acc = cyc; data1 = 16'hBEEF;
    wait_done("t3a", 300, dc);
    check("t3_done1_cyc", dc,  acc + 240);
    check("t3_gap_tx",    tx1, 1'b1);
    @(negedge clk);
    check("t3_second_start", tx1, 1'b0);
    valid1 = 1'b0;
    wait_done("t3b", 300, dc);
    check("t3_done2_cyc", dc, acc + 241 + 240);
    @(negedge clk);
    check_msg("t3a", 0, acc, 6);
    check_msg("t3b", 6, acc + 241, 6);
    check("t3_done_cnt", done_cnt, 2);

    // T4: capture at accept, i_valid ignored while busy
    clear_sb();
    push_str(8'h31, 8'h32, 8'h33, 8'h34, 1);
    data1 = 16'h1234; valid1 = 1'b1;
    @(negedge clk); acc = cyc; valid1 = 1'b0; data1 = 16'hABCD;
    repeat (50) @(negedge clk);
    valid1 = 1'b1;
    @(negedge clk);
    check("t4_ready_busy", ready1, 1'b0);
    valid1 = 1'b0;
    wait_done("t4", 300, dc);
    check("t4_done_cyc", dc, acc + 240);
    repeat (20) @(negedge clk);
    check("t4_rx_count", rx_q.size(), 6);
    check("t4_idle",     busy1,       1'b0);
    check("t4_done_cnt", done_cnt,    1);
    check_msg("t4", 0, acc, 6);

    // T5: reset during bit 3 of character 2 ('7' = 0x37, bit 3 = 0)
    clear_sb();
    data1 = 16'h5678; valid1 = 1'b1;
    @(negedge clk); acc = cyc; valid1 = 1'b0;
    repeat (97) @(negedge clk);
    check("t5_mid_bit3", tx1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_tx",    tx1,    1'b1);
    check("t5_rst_busy",  busy1,  1'b0);
    check("t5_rst_ready", ready1, 1'b1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done1 === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done1 === 1'b1) seen++;
    end
    check("t5_no_done", seen,  0);
    check("t5_idle_tx", tx1,   1'b1);
    check("t5_idle",    busy1, 1'b0);
    clear_sb();
    push_str(8'h30, 8'h30, 8'h46, 8'h46, 1);
    data1 = 16'h00FF; valid1 = 1'b1;
    @(negedge clk); acc = cyc; valid1 = 1'b0;
    wait_done("t5", 300, dc);
    check("t5_done_cyc", dc, acc + 240);
    @(negedge clk);
    check_msg("t5", 0, acc, 6);
    check("t5_ferr", ferr, 0);

    // T6: NEWLINE=0 instance
    sel = 1'b1;
    clear_sb();
    push_str(8'h43, 8'h30, 8'h44, 8'h45, 0);
    data2 = 16'hC0DE; valid2 = 1'b1;
    @(negedge clk); acc = cyc; valid2 = 1'b0;
    check("t6_latency_tx", tx2, 1'b0);
    wait_done("t6", 200, dc);
    check("t6_done_cyc", dc, acc + 160);
    repeat (20) @(negedge clk);
    check("t6_rx_count", rx_q.size(), 4);
    check_msg("t6", 0, acc, 4);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_ferr",     ferr,     0);
    check("t6_other_tx", tx1,      1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_hex_tx.md
Name: uart_hex_tx

Overview:
Transmit-side companion to the board's UART receive path. It accepts a 16-bit word over a valid/ready handshake and sends it on the UART TX pin as four uppercase ASCII hex digits, optionally followed by CR LF. Frames are 8N1, LSB first, and the block contains its own bit-level serializer. Typical use: echo received bytes, or dump RAM/debug values to a host terminal, alongside io_lcd.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (217*4 = 115200 baud at 100 MHz); legal range 2 or more
NEWLINE, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
i_valid  input  1  word available
i_data  input  16  word to send
o_ready  output  1  block idle and able to accept a word
o_tx  output  1  UART serial line; idles high
o_busy  output  1  high from the cycle after accept until the last stop bit ends
o_done  output  1  one-cycle pulse when the last stop bit of the message completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Values while rst=0: o_tx=1, o_busy=0, o_done=0, o_ready=1. i_valid is ignored while in reset. Internal state goes to IDLE; counters and registers clear to 0.
- Handshake: a word is accepted on a rising edge where i_valid=1 and o_ready=1. i_data is captured into a 16-bit register at that edge; later changes on i_data have no effect. o_ready=1 only in IDLE.
- Message: N = 4 + 2*NEWLINE characters, sent in this order:
  - hex(i_data[15:12]), hex([11:8]), hex([7:4]), hex([3:0])
  - then 0x0D, 0x0A when NEWLINE=1
- Hex mapping: n in 0..9 -> 0x30+n; n in 10..15 -> 0x37+n (uppercase 'A'..'F').
- Character framing:
  - start bit (0), then data bits d0..d7, then stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1.
  - Consecutive characters are contiguous: the next start bit follows the previous stop bit with no idle cycles.
- Latency: o_tx goes low on the first cycle after the accept edge. Total message time is N*10*CLKS_PER_BIT cycles.
- States: IDLE -> START -> DATA (bit index 0..7) -> STOP.
  - From STOP: if chars remain, go to START with the next character loaded; else return to IDLE.
  - Character index counts 0..N-1. The index for the current character selects a nibble or the CR/LF constant; no full message buffer is kept.
- Completion:
  - o_done pulses in the first IDLE cycle; o_ready=1 in that same cycle.
  - If i_valid=1 in that cycle, the next word is accepted immediately. The gap between the previous stop bit and the next start bit is then exactly 1 cycle, with o_tx=1.
- o_busy = (state != IDLE).
- Reset mid-message: o_tx returns high asynchronously and the message is abandoned. No o_done is produced, and no partial resume occurs after reset release.
- Widths:
  - baud counter: $clog2(CLKS_PER_BIT) bits.
  - bit index: 3 bits.
  - char index: 3 bits.
  - No counter overflows within legal parameter values.

Decomposition:
- Shared package (uart_pkg):
  - ASCII_CR = 8'h0D, ASCII_LF = 8'h0A
  - UART_DATA_BITS = 8
  - a nibble-to-ASCII function
  - state encoding typedef
- Sub-module uart_tx_byte: single-byte 8N1 serializer.
  - Ports: clk, rst, i_start, i_byte, o_tx, o_busy, o_bit_done_last.
  - Parameter: CLKS_PER_BIT.
  - It must accept i_start in its final stop cycle so that characters stay contiguous.
- uart_hex_tx itself is the message sequencer: char index, nibble select, handshake, done pulse.

Test Plan:
All benches use CLKS_PER_BIT=4 and NEWLINE=1 unless stated.
1. Basic message: reset, then i_data=16'h1A3F with i_valid for 1 cycle -> o_tx decodes to bytes 0x31 0x41 0x33 0x46 0x0D 0x0A. o_tx goes low 1 cycle after accept. o_done pulses exactly 240 cycles after the first start bit begins. o_busy is high throughout.
2. Bit timing: i_data=16'h0000 -> each low/high run has a length that is a multiple of 4 cycles. Char '0' = 0x30 yields the LSB-first pattern 0,0,0,0,0,1,1,0,0,1 (start bit included). No idle gaps between characters.
3. Back-to-back: i_valid held high with data 16'hFFFF then 16'hBEEF -> second accept in the o_done cycle. Exactly 1 high idle cycle between messages. Output decodes "FFFF\r\n" then "BEEF\r\n".
4. Capture: accept 16'h1234, then change i_data to 16'hABCD one cycle later -> "1234\r\n" is transmitted. i_valid is ignored while o_ready=0.
5. Reset mid-frame: assert rst low during bit 3 of character 2 -> o_tx=1 and o_busy=0 immediately, with no o_done. After release, a new word 16'h00FF transmits correctly as "00FF\r\n".
6. NEWLINE=0: i_data=16'hC0DE -> exactly 4 characters "C0DE"; o_done 160 cycles after the first start bit begins.
